// File: rtl/digilock_pkg.sv
// Shared types and helpers for the DigiLock keypad sequencer.
package digilock_pkg;

   typedef enum logic [2:0] {
      ENTRY,
      CHECK,
      OPEN,
      PROG,
      LOCKOUT
   } state_t;

   localparam logic [3:0] KEY_PROG  = 4'hA;
   localparam logic [3:0] KEY_CLEAR = 4'hB;

   function automatic logic is_digit(input logic [3:0] key);
      return (key <= 4'd9);
   endfunction

   // Width of a down-counter that must hold max(a,b)-1; never narrower than 1 bit.
   function automatic int timer_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/digilock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT durations.
module digilock_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_value,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/digilock_controller.sv
// DigiLock sequencer: code entry, check, door-open window, reprogramming and lockout.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ENTRY   | collecting digits, accumulating mismatch against stored code
//  CHECK   | one cycle: decide open vs fail, update tries
//  OPEN    | door unlocked for OPEN_CYCLES; PROG key enters programming
//  PROG    | shifting a new code into the shadow register
//  LOCKOUT | all keys ignored for LOCKOUT_CYCLES
module digilock_controller
   import digilock_pkg::*;
#(
   parameter int                    N_DIGITS       = 4,
   parameter int                    MAX_TRIES      = 3,
   parameter int                    OPEN_CYCLES    = 8,
   parameter int                    LOCKOUT_CYCLES = 16,
   parameter logic [4*N_DIGITS-1:0] RESET_CODE     = 16'h1234
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       open,
   output logic       locked_out,
   output logic       fail,
   output logic       prog_done,
   output logic [2:0] digit_count
);

   localparam int CW  = 4 * N_DIGITS;
   localparam int TW  = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);
   localparam int TRW = $clog2(MAX_TRIES + 1);

   localparam logic [2:0]     LAST_IDX   = 3'(N_DIGITS - 1);
   localparam logic [TW-1:0]  OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0]  LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TRW-1:0] TRIES_LAST = TRW'(MAX_TRIES - 1);
   localparam logic [TRW-1:0] TRIES_MAX  = TRW'(MAX_TRIES);

   state_t         state, state_nx;
   logic [CW-1:0]  code, code_nx;
   logic [CW-1:0]  shadow, shadow_nx;
   logic [2:0]     idx, idx_nx;
   logic           mismatch, mismatch_nx;
   logic [TRW-1:0] tries, tries_nx;
   logic           prog_store;

   logic           tmr_load;
   logic [TW-1:0]  tmr_value;
   logic           tmr_dec;
   logic           tmr_zero;

   logic           key_digit, key_clear, key_prog;
   logic [CW-1:0]  code_shift;
   logic [CW-1:0]  shadow_shift;

   assign key_digit    = key_valid && is_digit(key_code);
   assign key_clear    = key_valid && (key_code == KEY_CLEAR);
   assign key_prog     = key_valid && (key_code == KEY_PROG);
   // Digit idx of the stored code, most significant digit first.
   assign code_shift   = code >> {LAST_IDX - idx, 2'b00};
   assign shadow_shift = {shadow[CW-5:0], key_code};

   digilock_timer #(.W(TW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (tmr_load),
      .load_value (tmr_value),
      .dec        (tmr_dec),
      .zero       (tmr_zero)
   );

   always_comb begin
      state_nx    = state;
      code_nx     = code;
      shadow_nx   = shadow;
      idx_nx      = idx;
      mismatch_nx = mismatch;
      tries_nx    = tries;
      prog_store  = 1'b0;
      tmr_load    = 1'b0;
      tmr_value   = '0;
      tmr_dec     = 1'b0;

      case (state)
         ENTRY: begin
            if (key_digit) begin
               mismatch_nx = mismatch | (key_code != code_shift[3:0]);
               if (idx == LAST_IDX) begin
                  state_nx = CHECK;
                  idx_nx   = '0;
               end else begin
                  idx_nx = idx + 3'd1;
               end
            end else if (key_clear) begin
               idx_nx      = '0;
               mismatch_nx = 1'b0;
            end
         end
         CHECK: begin
            mismatch_nx = 1'b0;
            if (!mismatch) begin
               state_nx  = OPEN;
               tries_nx  = '0;
               tmr_load  = 1'b1;
               tmr_value = OPEN_LOAD;
            end else if (tries == TRIES_LAST) begin
               state_nx  = LOCKOUT;
               tries_nx  = '0;
               tmr_load  = 1'b1;
               tmr_value = LOCK_LOAD;
            end else begin
               state_nx = ENTRY;
               tries_nx = (tries == TRIES_MAX) ? tries : tries + TRW'(1);
            end
         end
         OPEN: begin
            tmr_dec = 1'b1;
            if (key_prog) begin
               state_nx = PROG;
               idx_nx   = '0;
            end else if (tmr_zero) begin
               state_nx = ENTRY;
            end
         end
         PROG: begin
            if (key_digit) begin
               shadow_nx = shadow_shift;
               if (idx == LAST_IDX) begin
                  code_nx    = shadow_shift;
                  prog_store = 1'b1;
                  state_nx   = ENTRY;
                  idx_nx     = '0;
               end else begin
                  idx_nx = idx + 3'd1;
               end
            end else if (key_clear) begin
               state_nx = ENTRY;
               idx_nx   = '0;
            end
         end
         LOCKOUT: begin
            tmr_dec = 1'b1;
            if (tmr_zero) begin
               state_nx = ENTRY;
               idx_nx   = '0;
            end
         end
         default: begin
            state_nx = ENTRY;
            idx_nx   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ENTRY;
         code     <= RESET_CODE;
         shadow   <= '0;
         idx      <= '0;
         mismatch <= 1'b0;
         tries    <= '0;
      end else begin
         state    <= state_nx;
         code     <= code_nx;
         shadow   <= shadow_nx;
         idx      <= idx_nx;
         mismatch <= mismatch_nx;
         tries    <= tries_nx;
      end
   end

   // Outputs are flopped from next-state values so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         open        <= 1'b0;
         locked_out  <= 1'b0;
         fail        <= 1'b0;
         prog_done   <= 1'b0;
         digit_count <= '0;
      end else begin
         open        <= (state_nx == OPEN);
         locked_out  <= (state_nx == LOCKOUT);
         fail        <= (state_nx == CHECK) && mismatch_nx;
         prog_done   <= prog_store;
         digit_count <= ((state_nx == ENTRY) || (state_nx == PROG)) ? idx_nx : 3'd0;
      end
   end

endmodule

// File: doc/digilock_controller.md
Name: digilock_controller

Overview:
Top-level sequencer for the DigiLock keypad lock. It accepts keypad codes, checks each entered digit against the stored code, and decides pass or fail after N_DIGITS digits. It drives the door-open and lockout outputs and lets the user reprogram the stored code while the door is open. It sits between the keypad decoder and the door/display logic.

Parameters:
N_DIGITS, 4, digits per code (2..8)
MAX_TRIES, 3, consecutive failed attempts before lockout
OPEN_CYCLES, 8, clock cycles the door stays open
LOCKOUT_CYCLES, 16, clock cycles of lockout
RESET_CODE, 16'h1234, code loaded at reset (4 bits per digit, MS digit first)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
key_valid  in  1  one-cycle strobe; key_code is valid in this cycle
key_code  in  4  0-9 = digit, 0xA = PROG, 0xB = CLEAR, 0xC-0xF = ignored
open  out  1  door unlocked (level)
locked_out  out  1  lockout active (level)
fail  out  1  one-cycle pulse on a failed attempt
prog_done  out  1  one-cycle pulse when a new code is stored
digit_count  out  3  digits entered in the current ENTRY or PROG sequence (display)

Behaviour:
- Reset is asynchronous on rst, with clock clk.
- Reset values: state = ENTRY, code register = RESET_CODE, idx = 0, mismatch = 0, tries = 0, timer = 0. All outputs are 0 during reset.
- All outputs are registered and Moore-style, taken from state and counters. fail and prog_done are high for exactly one cycle.
- ENTRY:
  - Digit key: compare against code digit[idx] and OR any mismatch into the mismatch flag. No early reveal of a wrong digit. Then idx++.
  - When the N_DIGITS-th digit is accepted: go to CHECK, idx = 0.
  - CLEAR: idx = 0, mismatch = 0, tries unchanged.
  - PROG and 0xC-0xF: ignored.
- CHECK (exactly 1 cycle):
  - mismatch = 0: go to OPEN, tries = 0, timer = OPEN_CYCLES-1.
  - mismatch = 1: fail = 1 for this cycle, tries++. If tries+1 == MAX_TRIES, go to LOCKOUT with timer = LOCKOUT_CYCLES-1 and tries = 0; otherwise go to ENTRY. mismatch is cleared.
- Latency: if the last digit is sampled at edge E0, open rises after edge E1 (state OPEN). fail is high during the cycle between E0 and E1.
- OPEN:
  - open = 1 for exactly OPEN_CYCLES cycles.
  - The timer decrements; at timer == 0 the next state is ENTRY.
  - PROG key: go to PROG immediately (open drops next cycle), idx = 0.
  - Other keys: ignored.
- PROG:
  - Digits shift into a shadow register, idx++.
  - On the N_DIGITS-th digit: the code register takes the shadow value in the same edge, prog_done pulses 1 cycle, next state is ENTRY.
  - CLEAR: abort to ENTRY; code unchanged, no prog_done.
  - There is no timeout.
- LOCKOUT:
  - locked_out = 1 for exactly LOCKOUT_CYCLES cycles.
  - All keys are ignored; keys pressed here are not buffered.
  - Then go to ENTRY with idx = 0.
- digit_count = idx in ENTRY and PROG, otherwise 0.
- A key_valid in the same cycle as a state transition is consumed by the current state only; it is never replayed.
- rst asserted mid-operation (any state) returns immediately to reset values, including code = RESET_CODE. A programmed code is not retained.
- Width rules:
  - tries width = clog2(MAX_TRIES+1); it saturates and never wraps.
  - timer width = clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES)).
  - The code register is 4*N_DIGITS bits.

Decomposition:
- Package digilock_pkg:
  - state enum {ENTRY, CHECK, OPEN, PROG, LOCKOUT}
  - key constants KEY_PROG = 4'hA, KEY_CLEAR = 4'hB
  - function is_digit(key)
  - width helper for the timer
- Sub-module digilock_timer: loadable down-counter with load, value and a zero flag, shared for the OPEN and LOCKOUT durations.
- The FSM, code register, shadow register and tries counter live in digilock_controller.

Test Plan:
- Correct code: after reset, keys 1,2,3,4 -> fail stays 0; open = 1 for exactly 8 cycles starting 2 edges after the '4' strobe; digit_count goes 1,2,3 then 0.
- Wrong then right: keys 1,2,3,5 -> fail pulse 1 cycle, open = 0. Then 1,2,3,4 -> open = 1 and tries is cleared (verify via 3 subsequent failures needed for lockout).
- Lockout: three wrong codes (9,9,9,9 x3) -> fail pulses x3, locked_out = 1 for 16 cycles. Keys 1,2,3,4 during lockout -> no open. After lockout, 1,2,3,4 -> open.
- Programming: unlock, PROG, keys 5,6,7,8 -> prog_done pulse. Then 1,2,3,4 -> fail; 5,6,7,8 -> open.
- CLEAR and abort:
  - 1,2,CLEAR,1,2,3,4 -> open, with no fail.
  - In PROG: 5,6,CLEAR -> code stays 1234.
  - Ignored key 0xE mid-entry does not advance digit_count.
- Async reset: rst during OPEN (cycle 3) and during PROG after 2 digits -> open = 0 immediately, code = 1234, digit_count = 0.
